// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a little-endian word-count header followed
// by little-endian instruction words over a byte stream and writes them into IMEM.
module inst_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              rx_rdy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, ERR} state_t;

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  state_t          state_reg;
  logic [1:0]      byte_cnt_reg;
  logic [23:0]     shift_reg;
  logic [ADDR_W:0] word_cnt_reg;
  logic [ADDR_W:0] n_words_reg;

  logic            rx_fire;
  logic [31:0]     word_full;
  logic [ADDR_W:0] word_cnt_inc;

  assign rx_fire      = rx_vld && rx_rdy;
  // The arriving byte completes the word on top of the three bytes already shifted in.
  assign word_full    = {rx_data, shift_reg};
  assign word_cnt_inc = word_cnt_reg + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      word_cnt_reg <= '0;
      n_words_reg  <= '0;
      rx_rdy       <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_hold    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ERR: begin
          if (start) begin
            state_reg    <= LEN;
            done         <= 1'b0;
            err          <= 1'b0;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            core_hold    <= 1'b1;
            rx_rdy       <= 1'b1;
          end
        end

        LEN: begin
          if (rx_fire) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= word_full[31:8];
            if (byte_cnt_reg == 2'd3) begin
              if (word_full == 32'd0) begin
                state_reg <= IDLE;
                done      <= 1'b1;
                core_hold <= 1'b0;
                rx_rdy    <= 1'b0;
              end else if ({1'b0, word_full} > DEPTH) begin
                state_reg <= ERR;
                err       <= 1'b1;
                rx_rdy    <= 1'b0;
              end else begin
                // Header is known to fit in ADDR_W+1 bits here.
                state_reg   <= DATA;
                n_words_reg <= word_full[ADDR_W:0];
              end
            end
          end
        end

        DATA: begin
          if (rx_fire) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= word_full[31:8];
            if (byte_cnt_reg == 2'd3) begin
              state_reg <= WRITE;
              mem_we    <= 1'b1;
              mem_waddr <= word_cnt_reg[ADDR_W-1:0];
              mem_wdata <= word_full;
              rx_rdy    <= 1'b0;
            end
          end
        end

        WRITE: begin
          mem_we       <= 1'b0;
          word_cnt_reg <= word_cnt_inc;
          if (word_cnt_inc == n_words_reg) begin
            state_reg <= IDLE;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state_reg <= DATA;
            rx_rdy    <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          rx_rdy    <= 1'b0;
          mem_we    <= 1'b0;
          core_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances (ADDR_W=10 and ADDR_W=4) share one byte stream;
// each has its own write scoreboard.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        a_rx_rdy, a_mem_we, a_core_hold, a_done, a_err;
  logic [9:0]  a_mem_waddr;
  logic [31:0] a_mem_wdata;
  logic        b_rx_rdy, b_mem_we, b_core_hold, b_done, b_err;
  logic [3:0]  b_mem_waddr;
  logic [31:0] b_mem_wdata;

  int checks = 0;
  int errors = 0;
  int wr_a = 0;
  int wr_b = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  always #5 clk = ~clk;

  inst_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_vld(rx_vld), .rx_data(rx_data),
    .rx_rdy(a_rx_rdy), .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata),
    .core_hold(a_core_hold), .done(a_done), .err(a_err)
  );

  inst_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .rx_vld(rx_vld), .rx_data(rx_data),
    .rx_rdy(b_rx_rdy), .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata),
    .core_hold(b_core_hold), .done(b_done), .err(b_err)
  );

  // Scoreboard monitors: every write pulse is matched against the next expected entry.
  always @(negedge clk) begin
    wr_t e;
    if (a_mem_we) begin
      wr_a++;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_write addr=%0d data=%h required no write", a_mem_waddr, a_mem_wdata);
      end else begin
        e = qa.pop_front();
        if ({22'd0, a_mem_waddr} !== e.addr || a_mem_wdata !== e.data) begin
          errors++;
          $display("FAIL a_write got addr=%0d data=%h required addr=%0d data=%h",
                   a_mem_waddr, a_mem_wdata, e.addr, e.data);
        end
      end
    end
    if (b_mem_we) begin
      wr_b++;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_write addr=%0d data=%h required no write", b_mem_waddr, b_mem_wdata);
      end else begin
        e = qb.pop_front();
        if ({28'd0, b_mem_waddr} !== e.addr || b_mem_wdata !== e.data) begin
          errors++;
          $display("FAIL b_write got addr=%0d data=%h required addr=%0d data=%h",
                   b_mem_waddr, b_mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  // All drive tasks start and end just after a negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    n = 0;
    while (!a_rx_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_rx_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h rx_rdy=%b required 1", b, a_rx_rdy);
    end
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic load_words(input int n, input bit to_b, input int gap);
    wr_t e;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      e.addr = i;
      e.data = w;
      qa.push_back(e);
      if (to_b) qb.push_back(e);
      send_word(w, gap);
    end
  endtask

  task automatic check_queues_empty(input string tag);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got qa=%0d qb=%0d required 0 0", tag, qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; rx_vld = 1'b1; rx_data = 8'h01;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0; rx_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_rx_rdy, a_mem_we, a_mem_waddr, a_mem_wdata, a_core_hold, a_done, a_err} !== '0) begin
      errors++;
      $display("FAIL reset_a got rdy=%b we=%b addr=%0d data=%h hold=%b done=%b err=%b required all 0",
               a_rx_rdy, a_mem_we, a_mem_waddr, a_mem_wdata, a_core_hold, a_done, a_err);
    end
    checks++;
    if ({b_rx_rdy, b_mem_we, b_mem_waddr, b_mem_wdata, b_core_hold, b_done, b_err} !== '0) begin
      errors++;
      $display("FAIL reset_b got rdy=%b we=%b addr=%0d data=%h hold=%b done=%b err=%b required all 0",
               b_rx_rdy, b_mem_we, b_mem_waddr, b_mem_wdata, b_core_hold, b_done, b_err);
    end
  endtask

  task automatic test_nominal();
    wr_t e;
    pulse_start();
    checks++;
    if (a_core_hold !== 1'b1 || a_rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_len got hold=%b rdy=%b required 1 1", a_core_hold, a_rx_rdy);
    end
    send_word(32'd2, 0);
    e.addr = 0; e.data = 32'h13; qa.push_back(e); qb.push_back(e);
    send_word(32'h13, 0);
    checks++;
    if (a_mem_we !== 1'b1 || a_core_hold !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_w0_latency got we=%b hold=%b done=%b required 1 1 0", a_mem_we, a_core_hold, a_done);
    end
    e.addr = 1; e.data = 32'h6F; qa.push_back(e); qb.push_back(e);
    send_word(32'h6F, 0);
    checks++;
    if (a_mem_we !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_w1_latency got we=%b done=%b required 1 0", a_mem_we, a_done);
    end
    @(negedge clk);
    checks++;
    if (a_core_hold !== 1'b0 || a_done !== 1'b1 || a_mem_we !== 1'b0 ||
        a_mem_waddr !== 10'd1 || a_mem_wdata !== 32'h6F || b_done !== 1'b1) begin
      errors++;
      $display("FAIL nominal_done got hold=%b done=%b we=%b addr=%0d data=%h b_done=%b required 0 1 0 1 0000006f 1",
               a_core_hold, a_done, a_mem_we, a_mem_waddr, a_mem_wdata, b_done);
    end
    check_queues_empty("nominal");
  endtask

  task automatic test_zero_len();
    int wa = wr_a;
    pulse_start();
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_cleared got %b required 0", a_done);
    end
    send_word(32'd0, 0);
    checks++;
    if (a_done !== 1'b1 || a_core_hold !== 1'b0 || a_rx_rdy !== 1'b0 || wr_a != wa) begin
      errors++;
      $display("FAIL zero_len got done=%b hold=%b rdy=%b writes=%0d required 1 0 0 0",
               a_done, a_core_hold, a_rx_rdy, wr_a - wa);
    end
  endtask

  task automatic test_oversize();
    int wa = wr_a;
    pulse_start();
    send_word(32'd1025, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (a_err !== 1'b1 || a_core_hold !== 1'b1 || a_rx_rdy !== 1'b0 || a_done !== 1'b0 || wr_a != wa) begin
      errors++;
      $display("FAIL oversize got err=%b hold=%b rdy=%b done=%b writes=%0d required 1 1 0 0 0",
               a_err, a_core_hold, a_rx_rdy, a_done, wr_a - wa);
    end
    pulse_start();
    checks++;
    if (a_err !== 1'b0 || a_rx_rdy !== 1'b1 || a_core_hold !== 1'b1) begin
      errors++;
      $display("FAIL oversize_restart got err=%b rdy=%b hold=%b required 0 1 1", a_err, a_rx_rdy, a_core_hold);
    end
    send_word(32'd0, 0);
    checks++;
    if (a_done !== 1'b1 || b_done !== 1'b1) begin
      errors++;
      $display("FAIL oversize_recover got a_done=%b b_done=%b required 1 1", a_done, b_done);
    end
  endtask

  task automatic test_start_ignored();
    wr_t e;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    e.addr = 0; e.data = 32'h44332211; qa.push_back(e); qb.push_back(e);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_core_hold !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got done=%b hold=%b required 1 0", a_done, a_core_hold);
    end
    check_queues_empty("start_ignored");
  endtask

  task automatic test_stall();
    wr_t e;
    int wa = wr_a;
    pulse_start();
    send_word(32'd1, 0);
    e.addr = 0; e.data = 32'hDEADBEEF; qa.push_back(e); qb.push_back(e);
    send_word(32'hDEADBEEF, 5);
    @(negedge clk);
    checks++;
    if (wr_a - wa != 1 || a_done !== 1'b1) begin
      errors++;
      $display("FAIL stall got writes=%0d done=%b required 1 1", wr_a - wa, a_done);
    end
    check_queues_empty("stall");
  endtask

  task automatic test_reset_mid();
    int wa = wr_a;
    int wb = wr_b;
    pulse_start();
    send_word(32'd4, 0);
    load_words(2, 1'b1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_rx_rdy, a_mem_we, a_mem_waddr, a_mem_wdata, a_core_hold, a_done, a_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got rdy=%b we=%b addr=%0d data=%h hold=%b done=%b err=%b required all 0",
               a_rx_rdy, a_mem_we, a_mem_waddr, a_mem_wdata, a_core_hold, a_done, a_err);
    end
    rx_data = 8'hCC;
    rx_vld  = 1'b1;
    repeat (6) @(negedge clk);
    rx_vld = 1'b0;
    checks++;
    if (wr_a - wa != 2 || wr_b - wb != 2 || a_rx_rdy !== 1'b0 || a_core_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_writes got a=%0d b=%0d rdy=%b hold=%b required 2 2 0 0",
               wr_a - wa, wr_b - wb, a_rx_rdy, a_core_hold);
    end
    check_queues_empty("reset_mid");
  endtask

  task automatic test_depth_small();
    pulse_start();
    send_word(32'd16, 0);
    load_words(16, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (b_done !== 1'b1 || b_err !== 1'b0 || b_mem_waddr !== 4'd15 || b_core_hold !== 1'b0) begin
      errors++;
      $display("FAIL depth16 got done=%b err=%b addr=%0d hold=%b required 1 0 15 0",
               b_done, b_err, b_mem_waddr, b_core_hold);
    end
    check_queues_empty("depth16");
  endtask

  task automatic test_over_small();
    int wb = wr_b;
    pulse_start();
    send_word(32'd17, 0);
    checks++;
    if (b_err !== 1'b1 || a_err !== 1'b0 || a_rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL over17 got b_err=%b a_err=%b a_rdy=%b required 1 0 1", b_err, a_err, a_rx_rdy);
    end
    load_words(17, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_mem_waddr !== 10'd16 || b_err !== 1'b1 || wr_b != wb) begin
      errors++;
      $display("FAIL over17_end got a_done=%b a_addr=%0d b_err=%b b_writes=%0d required 1 16 1 0",
               a_done, a_mem_waddr, b_err, wr_b - wb);
    end
    check_queues_empty("over17");
  endtask

  task automatic test_full_depth();
    pulse_start();
    send_word(32'd1024, 0);
    load_words(1024, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_err !== 1'b0 || a_mem_waddr !== 10'd1023 || a_core_hold !== 1'b0) begin
      errors++;
      $display("FAIL depth1024 got done=%b err=%b addr=%0d hold=%b required 1 0 1023 0",
               a_done, a_err, a_mem_waddr, a_core_hold);
    end
    check_queues_empty("depth1024");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_zero_len();
    test_oversize();
    test_start_ignored();
    test_stall();
    test_reset_mid();
    test_depth_small();
    test_over_small();
    test_full_depth();
    test_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
